// File: rtl/cmp_unit_arbiter.sv
// cmp_unit_arbiter: round-robin arbiter sharing one set-less-than comparator among NREQ requesters.
// Define CMP_ARB_PIPE_EN to allow a new grant in the same cycle a response is accepted.
module cmp_slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         uns,
  output logic         lt
);
  logic [N:0] sum;
  assign sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
  assign lt  = uns ? ~sum[N] : (a[N-1] & ~b[N-1]) | ((a[N-1] ~^ b[N-1]) & sum[N-1]);
endmodule

module cmp_unit_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_unsigned,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  input  logic              rsp_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_d;
  logic [IDW-1:0] rr_ptr, g, idx, id_q;
  logic [N-1:0] a_q, b_q;
  logic found, can_grant, grant, uns_q, lt;
  cmp_slt #(.N(N)) u_cmp (.a(a_q), .b(b_q), .uns(uns_q), .lt(lt));
  // first valid requester at or after rr_ptr, wrapping naturally on IDW bits
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
`ifdef CMP_ARB_PIPE_EN
  assign can_grant = (state == IDLE) | ((state == RESP) & rsp_ready);
`else
  assign can_grant = state == IDLE;
`endif
  assign grant     = can_grant & found;
  assign req_ready = grant ? (NREQ'(1) << g) : '0;
  always_comb begin
    state_d = state;
    if (grant) state_d = EXEC;
    else if (state == EXEC) state_d = RESP;
    else if (state == RESP && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      uns_q     <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state <= state_d;
      if (grant) begin
        a_q    <= req_a[g*N +: N];
        b_q    <= req_b[g*N +: N];
        uns_q  <= req_unsigned[g];
        id_q   <= g;
        rr_ptr <= g + 1'b1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= {{(N-1){1'b0}}, lt};
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cmp_unit_arbiter.sv
// tb_cmp_unit_arbiter: scoreboard bench; stimulus pushes expected grants/responses, a monitor pops and compares.
module tb_cmp_unit_arbiter;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int IDW = 2;
`ifdef CMP_ARB_PIPE_EN
  localparam int SP = 2;
`else
  localparam int SP = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_unsigned = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0] rsp_data;
  logic rsp_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_grant = -100;
  logic prev_valid = 1'b0;
  bit sp_on = 1'b0;
  int exp_grant[$];
  logic [IDW+N-1:0] exp_rsp[$];
  logic [IDW+N-1:0] mon_r;
  int gcyc[$];

  cmp_unit_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_unsigned(req_unsigned), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_valid = 1'b0;
    else begin
      if (rsp_valid && !prev_valid) chk("latency", 64'(cyc - last_grant), 64'(2));
      prev_valid = rsp_valid;
      if (req_ready != '0) begin
        if (exp_grant.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'(0));
        else chk("grant", 64'(req_ready), 64'(1) << exp_grant.pop_front());
        last_grant = cyc;
        if (sp_on) gcyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(mon_r[N +: IDW]));
          chk("rsp_data", 64'(rsp_data), 64'(mon_r[N-1:0]));
        end
      end
    end
  end

  task automatic set_req(int i, bit u, logic [N-1:0] a, logic [N-1:0] b);
    req_unsigned[i] = u;
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_op(int i, logic r);
    exp_grant.push_back(i);
    exp_rsp.push_back({IDW'(i), N'(r)});
  endtask

  task automatic wait_grants(int n, string name);
    int got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      @(negedge clk);
      if (req_ready != '0) got++;
    end
    chk(name, 64'(got), 64'(n));
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic drain(string name);
    for (int c = 0; c < 50 && (exp_rsp.size() != 0 || rsp_valid); c++) @(negedge clk);
    chk(name, 64'(exp_rsp.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(int i, bit u, logic [N-1:0] a, logic [N-1:0] b, logic r, string name);
    set_req(i, u, a, b);
    expect_op(i, r);
    wait_grants(1, name);
    drain(name);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ready", 64'(req_ready), 64'(0));
      chk("idle_valid", 64'(rsp_valid), 64'(0));
    end
    chk("reset_id", 64'(rsp_id), 64'(0));
    chk("reset_data", 64'(rsp_data), 64'(0));
    @(posedge clk);
    #1;
    do_op(0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "s_m1_lt_1");
    do_op(0, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "u_max_lt_1");
    do_op(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "s_min_lt_max");
    do_op(0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, "s_equal");
    do_op(0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "u_0_lt_max");
    do_op(2, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "u_max_lt_0");
    do_op(3, 0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "s_max_lt_min");
    do_op(1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, "s_m2_lt_m1");
    // reset while the op sits in EXEC: no response may follow
    set_req(0, 0, 32'h1, 32'h2);
    exp_grant.push_back(0);
    wait_grants(1, "grant_before_rst");
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_valid", 64'(rsp_valid), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    // all requesters continuously valid: grants 0,1,2,3,0,1,2,3
    sp_on = 1'b1;
    set_req(0, 0, 32'h1, 32'h2);
    set_req(1, 1, 32'hFFFF_FFFF, 32'h2);
    set_req(2, 0, 32'hFFFF_FFFF, 32'h0);
    set_req(3, 1, 32'h3, 32'h3);
    for (int r = 0; r < 2; r++) begin
      expect_op(0, 1'b1);
      expect_op(1, 1'b0);
      expect_op(2, 1'b1);
      expect_op(3, 1'b0);
    end
    wait_grants(8, "grant_rr8");
    drain("drain_rr8");
    sp_on = 1'b0;
    chk("gcount", 64'(gcyc.size()), 64'(8));
    for (int k = 1; k < gcyc.size(); k++) chk("spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(SP));
    // backpressure with another requester pending
    rsp_ready = 1'b0;
    set_req(1, 0, 32'h10, 32'h20);
    set_req(2, 1, 32'h20, 32'h10);
    expect_op(1, 1'b1);
    expect_op(2, 1'b0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (req_ready == '0 && c < 20);
    chk("bp_grant_seen", 64'(req_ready != '0), 64'(1));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!rsp_valid && c < 20);
    chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_id", 64'(rsp_id), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(1));
      chk("bp_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grants(1, "grant_after_bp");
    drain("drain_bp");
    // rr_ptr moves to 2, then req1 and req3 compete: 3 wins first
    do_op(1, 1, 32'h7, 32'h8, 1'b1, "u_7_lt_8");
    set_req(1, 1, 32'h9, 32'h8);
    set_req(3, 0, 32'h8000_0000, 32'h0);
    expect_op(3, 1'b1);
    expect_op(1, 1'b0);
    wait_grants(2, "grant_rr_skip");
    drain("drain_rr_skip");
    repeat (3) @(negedge clk);
    chk("grant_queue_empty", 64'(exp_grant.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_unit_arbiter.md
Name: cmp_unit_arbiter

Overview:
- Shares one set-less-than comparator (signed/unsigned, result zero-extended to N bits) among NREQ requesters.
- Round-robin arbitration, operand latching, a 3-state sequencer and a single response channel tagged with the requester ID.
- Sits between the integer-arithmetic issue logic of several cores/lanes and the shared comparator datapath.
- The comparator is instantiated internally.

Parameters:
- N, 32, operand/result width (N >= 2).
- NREQ, 4, number of requesters (power of two, >= 2).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  request valid, bit i = requester i
- req_ready  output  NREQ  one-hot grant/accept pulse
- req_unsigned  input  NREQ  1 = unsigned compare for requester i
- req_a  input  NREQ*N  operand a, requester i at bits [i*N +: N]
- req_b  input  NREQ*N  operand b, same packing
- rsp_valid  output  1  response valid
- rsp_id  output  IDW  requester that owns the response
- rsp_data  output  N  {(N-1) zeros, a<b}
- rsp_ready  input  1  consumer accepts response

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0, operand regs=0. Reset mid-operation drops any in-flight op silently; no response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid: grant the first set bit searching from rr_ptr upward, wrapping at NREQ-1 -> 0.
  - req_ready[g]=1 combinationally this cycle; a handshake occurs because req_valid[g]=1.
  - Latch a, b, unsigned and ID g; set rr_ptr=(g+1) mod NREQ; go to EXEC.
  - No valid: stay in IDLE, req_ready=0.
- EXEC: the comparator evaluates the latched operands; register rsp_data, rsp_id; rsp_valid<=1; go to RESP. req_ready=0.
- RESP: hold rsp_valid, rsp_id, rsp_data stable until rsp_ready=1. On rsp_ready: rsp_valid<=0; go to IDLE (see optional feature). req_ready=0.
- Latency: grant at cycle T -> rsp_valid first high at T+2. Base throughput: one op per 3 cycles with rsp_ready held high.
- Compare rules:
  - Unsigned: lt = a < b as unsigned (borrow of a + ~b + 1, i.e. lt = !carry_out).
  - Signed: two's complement. lt = (a[N-1] & !b[N-1]) | ((a[N-1]==b[N-1]) & diff[N-1]), where diff = a-b mod 2^N.
  - a==b gives 0 in both modes.
  - rsp_data upper N-1 bits are always 0.
- Requester-side rules:
  - A requester must hold req_valid and operands stable until it sees req_ready; the arbiter samples operands only in the grant cycle.
  - req_valid dropping without a grant is legal; no state changes.
- Fairness: a continuously-requesting requester waits at most NREQ-1 grants.
- Responses come back in grant order. Only one op is ever in flight, so there is no reordering.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: CMP_ARB_PIPE_EN.
- Defined:
  - In RESP, when rsp_ready=1 and any req_valid=1, perform the IDLE grant in the same cycle and go directly to EXEC.
  - req_ready may pulse in RESP only in that handshake cycle.
  - Sustained throughput becomes one op per 2 cycles.
  - rsp_valid deasserts for exactly one cycle (EXEC) between back-to-back responses.
- Not defined: RESP always returns to IDLE, and req_ready is never asserted outside IDLE.

Test Plan:
- Reset release, no requests -> req_ready=0, rsp_valid=0 for 10 cycles; assert rst_n=0 in EXEC -> rsp_valid stays 0, state back to IDLE, no response emitted after release.
- N=32, req0 signed a=0xFFFFFFFF(-1), b=0x00000001 -> req_ready[0] at T, rsp_valid at T+2, rsp_data=1, rsp_id=0; same operands unsigned -> rsp_data=0.
- Boundary compares, signed: a=0x80000000, b=0x7FFFFFFF -> 1; a=b=0x12345678 -> 0. Unsigned: a=0, b=0xFFFFFFFF -> 1.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; rsp_id follows the same order; each grant 3 cycles apart (2 with CMP_ARB_PIPE_EN).
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_data stable, req_ready=0 throughout; rsp_ready=1 -> accepted, next grant follows rules.
- rr_ptr=2 with only req1 and req3 valid -> req3 granted first, then req1.
